// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I main FSM plus ALU decoder, stalling on mem_ready
// Ports: clk/reset (sync, active-high); op/funct3/funct7b5 from the instruction register;
// zero ALU flag; mem_ready memory handshake; pcwrite/adrsrc/memwrite/irwrite/resultsrc/
// alusrca/alusrcb/alucontrol/regwrite/immsrc datapath controls; illegal sticky trap flag.
// Define ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they behave as nops.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] alucontrol,
    output logic       regwrite,
    output logic [1:0] immsrc,
    output logic       illegal
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP
    } state_t;
    state_t state, next;
    logic is_lw, is_sw, is_r, is_i, is_beq, is_jal;
    logic pcupdate, branch, irw, mw, rw;
    logic [1:0] aluop;
    assign is_lw  = op == 7'b0000011;
    assign is_sw  = op == 7'b0100011;
    assign is_r   = op == 7'b0110011;
    assign is_i   = op == 7'b0010011;
    assign is_beq = op == 7'b1100011;
    assign is_jal = op == 7'b1101111;
    assign immsrc = is_sw ? 2'b01 : is_beq ? 2'b10 : is_jal ? 2'b11 : 2'b00;
    always_comb begin
        next = state;
        case (state)
            FETCH:    next = mem_ready ? DECODE : FETCH;
            DECODE:   next = (is_lw | is_sw) ? MEMADR : is_r ? EXECUTER : is_i ? EXECUTEI :
                             is_beq ? BEQ : is_jal ? JAL :
`ifdef ILLEGAL_TRAP_EN
                             TRAP;
`else
                             FETCH;
`endif
            MEMADR:   next = is_sw ? MEMWRITE : MEMREAD;
            MEMREAD:  next = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    next = FETCH;
            MEMWRITE: next = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: next = ALUWB;
            EXECUTEI: next = ALUWB;
            ALUWB:    next = FETCH;
            BEQ:      next = FETCH;
            JAL:      next = ALUWB;
            TRAP:     next = TRAP;
            default:  next = FETCH;
        endcase
    end
`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= next;
            if (next == TRAP) illegal_q <= 1'b1;
        end
    end
    assign illegal = illegal_q;
`else
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else state <= next;
    end
    assign illegal = 1'b0;
`endif
    always_comb begin
        pcupdate  = 1'b0;
        branch    = 1'b0;
        irw       = 1'b0;
        mw        = 1'b0;
        rw        = 1'b0;
        adrsrc    = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        case (state)
            FETCH: begin
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irw       = mem_ready;
                pcupdate  = mem_ready;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            MEMREAD:  adrsrc = 1'b1;
            MEMWB: begin
                resultsrc = 2'b01;
                rw        = 1'b1;
            end
            MEMWRITE: begin
                adrsrc = 1'b1;
                mw     = 1'b1;
            end
            EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB:    rw = 1'b1;
            BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end
    // funct7b5 selects sub only for R-type (op[5]); I-type addi ignores it
    assign alucontrol = aluop == 2'b00 ? 3'b000 :
                        aluop == 2'b01 ? 3'b001 :
                        funct3 == 3'b000 ? ((op[5] & funct7b5) ? 3'b001 : 3'b000) :
                        funct3 == 3'b010 ? 3'b101 :
                        funct3 == 3'b110 ? 3'b011 :
                        funct3 == 3'b111 ? 3'b010 : 3'b000;
    // write enables are suppressed while reset is held so an abandoned access leaves no trace
    assign pcwrite  = ~reset & (pcupdate | (branch & zero));
    assign irwrite  = ~reset & irw;
    assign memwrite = ~reset & mw;
    assign regwrite = ~reset & rw;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed scoreboard bench for mc_controller
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b1;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    int total = 0;
    int bad = 0;
    logic [16:0] exp_q[$];
    string tag_q[$];
    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
        .memwrite(memwrite), .irwrite(irwrite), .resultsrc(resultsrc),
        .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
        .regwrite(regwrite), .immsrc(immsrc), .illegal(illegal)
    );
    always #5 clk = ~clk;
    function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs, input logic [1:0] ra,
                                      input logic [1:0] rb, input logic [2:0] alu,
                                      input logic rw, input logic [1:0] imm, input logic ill);
        return {pcw, adr, mw, irw, rs, ra, rb, alu, rw, imm, ill};
    endfunction
    function automatic logic [16:0] fetch(input logic [1:0] imm);
        return v(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, imm, 0);
    endfunction
    function automatic logic [16:0] stall(input logic [1:0] imm);
        return v(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, imm, 0);
    endfunction
    function automatic logic [16:0] decode(input logic [1:0] imm);
        return v(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0);
    endfunction
    function automatic logic [16:0] aluwb(input logic [1:0] imm);
        return v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, imm, 0);
    endfunction
    task automatic chk(input string tag, input logic [16:0] e);
        logic [16:0] obs, want;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        obs = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
               alucontrol, regwrite, immsrc, illegal};
        want = exp_q.pop_front();
        t = tag_q.pop_front();
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", t, obs, want);
        end
        @(negedge clk);
    endtask
    initial begin
        @(negedge clk);
        chk("reset_fetch", stall(2'b00));
        reset = 1'b0;
        chk("r_fetch", fetch(2'b00));
        chk("r_decode", decode(2'b00));
        chk("r_exec_sub", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 2'b00, 0));
        chk("r_aluwb", aluwb(2'b00));
        op = 7'b0110011; funct3 = 3'b010; funct7b5 = 1'b0;
        chk("slt_fetch", fetch(2'b00));
        chk("slt_decode", decode(2'b00));
        chk("r_exec_slt", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 0, 2'b00, 0));
        chk("slt_aluwb", aluwb(2'b00));
        op = 7'b0010011; funct3 = 3'b110; funct7b5 = 1'b1;
        chk("ori_fetch", fetch(2'b00));
        chk("ori_decode", decode(2'b00));
        chk("i_exec_or", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b011, 0, 2'b00, 0));
        chk("ori_aluwb", aluwb(2'b00));
        funct3 = 3'b000;
        chk("addi_fetch", fetch(2'b00));
        chk("addi_decode", decode(2'b00));
        chk("i_exec_add", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 2'b00, 0));
        chk("addi_aluwb", aluwb(2'b00));
        op = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b0;
        chk("lw_fetch_stall", stall(2'b00));
        mem_ready = 1'b1;
        chk("lw_fetch", fetch(2'b00));
        chk("lw_decode", decode(2'b00));
        chk("lw_memadr", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 2'b00, 0));
        mem_ready = 1'b0;
        chk("lw_memread1", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 0));
        chk("lw_memread2", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 0));
        mem_ready = 1'b1;
        chk("lw_memread3", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 0));
        chk("lw_memwb", v(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 2'b00, 0));
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        chk("beq_t_fetch", fetch(2'b10));
        chk("beq_t_decode", decode(2'b10));
        chk("beq_taken", v(1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 2'b10, 0));
        zero = 1'b0;
        chk("beq_n_fetch", fetch(2'b10));
        chk("beq_n_decode", decode(2'b10));
        chk("beq_not_taken", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 2'b10, 0));
        op = 7'b1101111;
        chk("jal_fetch", fetch(2'b11));
        chk("jal_decode", decode(2'b11));
        chk("jal_state", v(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 2'b11, 0));
        chk("jal_aluwb", aluwb(2'b11));
        op = 7'b0100011;
        chk("sw_fetch", fetch(2'b01));
        chk("sw_decode", decode(2'b01));
        chk("sw_memadr", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 2'b01, 0));
        mem_ready = 1'b0;
        chk("sw_memwrite_stall", v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b01, 0));
        reset = 1'b1;
        chk("sw_reset_gated", v(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b01, 0));
        reset = 1'b0;
        chk("sw_abandoned_fetch", stall(2'b01));
        mem_ready = 1'b1;
        chk("sw2_fetch", fetch(2'b01));
        chk("sw2_decode", decode(2'b01));
        chk("sw2_memadr", v(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 2'b01, 0));
        chk("sw2_memwrite", v(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b01, 0));
        op = 7'b1111111;
        chk("ill_fetch", fetch(2'b00));
        chk("ill_decode", decode(2'b00));
`ifdef ILLEGAL_TRAP_EN
        chk("ill_trap1", v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 1));
        chk("ill_trap2", v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 1));
        reset = 1'b1;
        chk("ill_trap_reset", v(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 1));
        reset = 1'b0;
        chk("ill_cleared", fetch(2'b00));
`else
        chk("ill_nop_fetch", fetch(2'b00));
        chk("ill_nop_decode", decode(2'b00));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
